mirfak_bus_arbiter: RTL and testbench

Two-master to one-slave Wishbone (classic) arbiter. It shares the core's single external memory port between the instruction fetch port (iport, read-only) and the load/store port (dport).
- dport has fixed priority, because a busy LSU stalls the whole pipeline through the stall/kill controller.
- A starvation counter guarantees that fetch eventually gets the bus.
- Sits between the core's fetch/LSU master ports and the SoC bus.

---
 rtl/mirfak_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_mirfak_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mirfak_bus_arbiter.sv
// Two-master (fetch, load/store) to one-slave Wishbone classic arbiter; dport has priority, with a starvation cap for iport.
// Grant one cycle after request; one dead IDLE cycle after each ack/err; grants are never preempted.
module mirfak_bus_arbiter #(
  parameter int unsigned DPORT_MAX_GNT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iport_addr_i,
  input  logic        iport_cyc_i,
  input  logic        iport_stb_i,
  output logic        iport_ack_o,
  output logic        iport_err_o,
  input  logic [31:0] dport_addr_i,
  input  logic [31:0] dport_dat_i,
  input  logic [3:0]  dport_sel_i,
  input  logic        dport_we_i,
  input  logic        dport_cyc_i,
  input  logic        dport_stb_i,
  output logic        dport_ack_o,
  output logic        dport_err_o,
  output logic [31:0] rsp_dat_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;

  logic w_req_i;
  logic w_req_d;
  logic w_force_i;
  logic w_done;

  assign w_req_i   = iport_cyc_i & iport_stb_i;
  assign w_req_d   = dport_cyc_i & dport_stb_i;
  // iport has waited through the maximum run of dport grants
  assign w_force_i = w_req_i && (r_cnt == 4'(DPORT_MAX_GNT));
  assign w_done    = wbm_ack_i | wbm_err_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_d && !w_force_i) begin
            r_state <= GNT_D;
            if (w_req_i)
              r_cnt <= (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
            else
              r_cnt <= 4'd0;
          end else if (w_req_i) begin
            r_state <= GNT_I;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt   <= 4'd0;
          end
        end
        GNT_I: begin
          if (w_done || !iport_cyc_i)
            r_state <= IDLE;
        end
        GNT_D: begin
          if (w_done || !dport_cyc_i)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus muxing is combinational on the registered grant so aborts and resets drop cyc at once
  always_comb begin
    wbm_addr_o  = 32'd0;
    wbm_dat_o   = 32'd0;
    wbm_sel_o   = 4'd0;
    wbm_we_o    = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    iport_ack_o = 1'b0;
    iport_err_o = 1'b0;
    dport_ack_o = 1'b0;
    dport_err_o = 1'b0;
    case (r_state)
      GNT_I: begin
        wbm_addr_o  = iport_addr_i;
        wbm_sel_o   = 4'hF;
        wbm_cyc_o   = iport_cyc_i;
        wbm_stb_o   = iport_stb_i;
        iport_ack_o = wbm_ack_i & ~wbm_err_i;
        iport_err_o = wbm_err_i;
      end
      GNT_D: begin
        wbm_addr_o  = dport_addr_i;
        wbm_dat_o   = dport_dat_i;
        wbm_sel_o   = dport_sel_i;
        wbm_we_o    = dport_we_i;
        wbm_cyc_o   = dport_cyc_i;
        wbm_stb_o   = dport_stb_i;
        dport_ack_o = wbm_ack_i & ~wbm_err_i;
        dport_err_o = wbm_err_i;
      end
      default: ;
    endcase
  end

  assign rsp_dat_o = wbm_dat_i;

endmodule

// File: tb/tb_mirfak_bus_arbiter.sv
// Directed bench for mirfak_bus_arbiter: hand-computed expectations for grant order, routing, aborts and reset.
module tb_mirfak_bus_arbiter;

  localparam logic [31:0] IADDR = 32'h0000_3000;
  localparam logic [31:0] DADDR = 32'h0000_2000;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] iport_addr_i;
  logic        iport_cyc_i;
  logic        iport_stb_i;
  logic        iport_ack_o;
  logic        iport_err_o;
  logic [31:0] dport_addr_i;
  logic [31:0] dport_dat_i;
  logic [3:0]  dport_sel_i;
  logic        dport_we_i;
  logic        dport_cyc_i;
  logic        dport_stb_i;
  logic        dport_ack_o;
  logic        dport_err_o;
  logic [31:0] rsp_dat_o;
  logic [31:0] wbm_addr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  int n_chk = 0;
  int n_err = 0;
  logic was_i;

  mirfak_bus_arbiter #(.DPORT_MAX_GNT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iport_addr_i(iport_addr_i), .iport_cyc_i(iport_cyc_i), .iport_stb_i(iport_stb_i),
    .iport_ack_o(iport_ack_o), .iport_err_o(iport_err_o),
    .dport_addr_i(dport_addr_i), .dport_dat_i(dport_dat_i), .dport_sel_i(dport_sel_i),
    .dport_we_i(dport_we_i), .dport_cyc_i(dport_cyc_i), .dport_stb_i(dport_stb_i),
    .dport_ack_o(dport_ack_o), .dport_err_o(dport_err_o),
    .rsp_dat_o(rsp_dat_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_inputs();
    iport_addr_i = 32'd0; iport_cyc_i = 1'b0; iport_stb_i = 1'b0;
    dport_addr_i = 32'd0; dport_dat_i = 32'd0; dport_sel_i = 4'd0;
    dport_we_i = 1'b0; dport_cyc_i = 1'b0; dport_stb_i = 1'b0;
    wbm_dat_i = 32'd0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
  endtask

  task automatic wait_stb();
    #1;
    for (int w = 0; w < 12 && !wbm_stb_o; w++) begin
      cyc();
      #1;
    end
    check("stb_wait", 32'(wbm_stb_o), 32'd1);
  endtask

  // Waits for a grant, acks it for one cycle, and reports which master owned it
  task automatic serve_one(output logic who_i);
    wait_stb();
    who_i = (wbm_addr_o == IADDR);
    wbm_ack_i = 1'b1;
    cyc();
    wbm_ack_i = 1'b0;
    if (who_i) begin
      iport_cyc_i = 1'b0;
      iport_stb_i = 1'b0;
    end
    #1;
    check("dead_cycle", 32'(wbm_cyc_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_i = 1'b0;
    #3;
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_iack", 32'(iport_ack_o), 32'd0);
    check("rst_dack", 32'(dport_ack_o), 32'd0);
    #9;
    rst_i = 1'b1;
    cyc();

    // iport-only read
    iport_addr_i = 32'h8000_0000; iport_cyc_i = 1'b1; iport_stb_i = 1'b1;
    #1;
    check("t1_stb_req_cycle", 32'(wbm_stb_o), 32'd0);
    cyc();
    check("t1_stb", 32'(wbm_stb_o), 32'd1);
    check("t1_addr", wbm_addr_o, 32'h8000_0000);
    check("t1_we", 32'(wbm_we_o), 32'd0);
    check("t1_sel", 32'(wbm_sel_o), 32'hF);
    check("t1_dat", wbm_dat_o, 32'd0);
    cyc();
    check("t1_iack_wait", 32'(iport_ack_o), 32'd0);
    cyc();
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
    #1;
    check("t1_iack", 32'(iport_ack_o), 32'd1);
    check("t1_rsp", rsp_dat_o, 32'h1234_5678);
    check("t1_dack", 32'(dport_ack_o), 32'd0);
    cyc();
    wbm_ack_i = 1'b0; iport_cyc_i = 1'b0; iport_stb_i = 1'b0;
    #1;
    check("t1_iack_drop", 32'(iport_ack_o), 32'd0);
    check("t1_idle_cyc", 32'(wbm_cyc_o), 32'd0);

    // simultaneous requests: dport write first, then iport
    cyc();
    iport_addr_i = 32'h8000_0004; iport_cyc_i = 1'b1; iport_stb_i = 1'b1;
    dport_addr_i = 32'h0000_1000; dport_dat_i = 32'hDEAD_BEEF; dport_sel_i = 4'hF;
    dport_we_i = 1'b1; dport_cyc_i = 1'b1; dport_stb_i = 1'b1;
    cyc();
    check("t2_we", 32'(wbm_we_o), 32'd1);
    check("t2_dat", wbm_dat_o, 32'hDEAD_BEEF);
    check("t2_addr", wbm_addr_o, 32'h0000_1000);
    check("t2_sel", 32'(wbm_sel_o), 32'hF);
    wbm_ack_i = 1'b1;
    #1;
    check("t2_dack", 32'(dport_ack_o), 32'd1);
    check("t2_iack", 32'(iport_ack_o), 32'd0);
    cyc();
    wbm_ack_i = 1'b0; dport_cyc_i = 1'b0; dport_stb_i = 1'b0; dport_we_i = 1'b0;
    #1;
    check("t2_dead", 32'(wbm_cyc_o), 32'd0);
    cyc();
    check("t2_igrant_addr", wbm_addr_o, 32'h8000_0004);
    check("t2_igrant_we", 32'(wbm_we_o), 32'd0);
    check("t2_igrant_cyc", 32'(wbm_cyc_o), 32'd1);
    wbm_ack_i = 1'b1;
    cyc();
    wbm_ack_i = 1'b0; iport_cyc_i = 1'b0; iport_stb_i = 1'b0;

    // starvation cap: D D D D I D
    cyc();
    iport_addr_i = IADDR; iport_cyc_i = 1'b1; iport_stb_i = 1'b1;
    dport_addr_i = DADDR; dport_cyc_i = 1'b1; dport_stb_i = 1'b1;
    for (int g = 0; g < 6; g++) begin
      serve_one(was_i);
      check($sformatf("t3_grant%0d_is_i", g), 32'(was_i), (g == 4) ? 32'd1 : 32'd0);
    end
    dport_cyc_i = 1'b0; dport_stb_i = 1'b0;
    cyc();

    // err and ack together in GNT_D, then an ack while idle
    dport_cyc_i = 1'b1; dport_stb_i = 1'b1;
    cyc();
    check("t4_cyc", 32'(wbm_cyc_o), 32'd1);
    wbm_err_i = 1'b1; wbm_ack_i = 1'b1;
    #1;
    check("t4_derr", 32'(dport_err_o), 32'd1);
    check("t4_dack", 32'(dport_ack_o), 32'd0);
    check("t4_iack", 32'(iport_ack_o), 32'd0);
    check("t4_ierr", 32'(iport_err_o), 32'd0);
    cyc();
    wbm_err_i = 1'b0; wbm_ack_i = 1'b0; dport_cyc_i = 1'b0; dport_stb_i = 1'b0;
    #1;
    check("t4_idle", 32'(wbm_cyc_o), 32'd0);
    wbm_ack_i = 1'b1;
    #1;
    check("t4_idle_iack", 32'(iport_ack_o), 32'd0);
    check("t4_idle_dack", 32'(dport_ack_o), 32'd0);
    cyc();
    wbm_ack_i = 1'b0;
    #1;
    check("t4_still_idle", 32'(wbm_cyc_o), 32'd0);

    // iport abort, followed by a dport grant after the dead cycle
    iport_addr_i = IADDR; iport_cyc_i = 1'b1; iport_stb_i = 1'b1;
    cyc();
    check("t5_icyc", 32'(wbm_cyc_o), 32'd1);
    iport_cyc_i = 1'b0;
    dport_addr_i = DADDR; dport_cyc_i = 1'b1; dport_stb_i = 1'b1;
    #1;
    check("t5_abort_same_cycle", 32'(wbm_cyc_o), 32'd0);
    cyc();
    check("t5_dead", 32'(wbm_cyc_o), 32'd0);
    cyc();
    check("t5_dgrant_cyc", 32'(wbm_cyc_o), 32'd1);
    check("t5_dgrant_addr", wbm_addr_o, DADDR);
    wbm_ack_i = 1'b1;
    cyc();
    wbm_ack_i = 1'b0; dport_cyc_i = 1'b0; dport_stb_i = 1'b0; iport_stb_i = 1'b0;
    cyc();

    // reset during the 4th consecutive dport grant clears the starvation count
    iport_addr_i = IADDR; iport_cyc_i = 1'b1; iport_stb_i = 1'b1;
    dport_addr_i = DADDR; dport_cyc_i = 1'b1; dport_stb_i = 1'b1;
    for (int g = 0; g < 3; g++) begin
      serve_one(was_i);
      check($sformatf("t6_pre%0d_is_i", g), 32'(was_i), 32'd0);
    end
    wait_stb();
    check("t6_in_gnt_d", wbm_addr_o, DADDR);
    rst_i = 1'b0;
    #1;
    check("t6_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("t6_rst_stb", 32'(wbm_stb_o), 32'd0);
    wbm_ack_i = 1'b1;
    #1;
    check("t6_rst_dack", 32'(dport_ack_o), 32'd0);
    cyc();
    wbm_ack_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("t6_post_rst_idle", 32'(wbm_cyc_o), 32'd0);
    serve_one(was_i);
    check("t6_cnt_cleared_is_i", 32'(was_i), 32'd0);
    dport_cyc_i = 1'b0; dport_stb_i = 1'b0;
    serve_one(was_i);
    check("t6_lone_iport_is_i", 32'(was_i), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
